// File: rtl/gate_detector.sv
// rtl/gate_detector.sv - debounced threshold gate pulse generator feeding the IAGC watchdog
//
// Purpose: while the IAGC status is IDLE, watch the valid sample stream. A sample at
// or below the low threshold arms the detector. DEBOUNCE valid samples at or above the
// high threshold then fire a registered one-cycle gate pulse, followed by HOLDOFF cycles
// of dead time. Emitted gates are counted with saturation.
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          synchronous active-high reset
//   i_iagcStatus     IAGC status; detection runs only in IAGC_STATUS_IDLE
//   i_sampleValid    qualifies i_sample
//   i_sample         unsigned input sample
//   i_thresholdHigh  fire level
//   i_thresholdLow   re-arm level
//   o_gate           single-cycle gate pulse
//   o_busy           high while ARMED or in HOLDOFF
//   o_cfgError       registered flag, low threshold >= high threshold
//   o_gateCount      saturating count of emitted gates
module gate_detector #(
    parameter int                          DATA_SIZE        = 12,
    parameter int                          IAGC_STATUS_SIZE = 4,
    parameter logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_INIT = 4'b0001,
    parameter logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_IDLE = 4'b0010,
    parameter int                          DEBOUNCE         = 4,
    parameter int                          HOLDOFF          = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [IAGC_STATUS_SIZE-1:0] i_iagcStatus,
    input  logic                        i_sampleValid,
    input  logic [DATA_SIZE-1:0]        i_sample,
    input  logic [DATA_SIZE-1:0]        i_thresholdHigh,
    input  logic [DATA_SIZE-1:0]        i_thresholdLow,
    output logic                        o_gate,
    output logic                        o_busy,
    output logic                        o_cfgError,
    output logic [15:0]                 o_gateCount
);

    localparam int DEB_W  = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOW = 2'd0,
        S_ARMED    = 2'd1,
        S_HOLDOFF  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [DEB_W-1:0]    deb;
    logic [DEB_W-1:0]    deb_n;
    logic [DEB_W-1:0]    deb_inc;
    logic [HOLD_W-1:0]   hold;
    logic [HOLD_W-1:0]   hold_n;
    logic                fire;
    logic                cfg_bad_now;
    logic                cfg_error_q;
    logic                blocked;
    logic                is_idle;
    logic                is_init;
    logic                above_high;
    logic                at_or_below_low;
    logic                gate_q;
    logic [15:0]         gate_count;

    assign cfg_bad_now     = (i_thresholdLow >= i_thresholdHigh);
    // The registered flag lags a cycle, so the live comparison also blocks the FSM
    // to keep a bad threshold pair from slipping a transition through.
    assign blocked         = cfg_error_q | cfg_bad_now;
    assign is_idle         = (i_iagcStatus == IAGC_STATUS_IDLE);
    assign is_init         = (i_iagcStatus == IAGC_STATUS_INIT);
    assign above_high      = (i_sample >= i_thresholdHigh);
    assign at_or_below_low = (i_sample <= i_thresholdLow);
    assign deb_inc         = deb + DEB_W'(1);

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= S_WAIT_LOW;
            deb         <= '0;
            hold        <= '0;
            gate_q      <= 1'b0;
            cfg_error_q <= 1'b0;
            gate_count  <= '0;
        end else begin
            state       <= state_n;
            deb         <= deb_n;
            hold        <= hold_n;
            gate_q      <= fire;
            cfg_error_q <= cfg_bad_now;
            if (is_init) begin
                gate_count <= '0;
            end else if (fire && (gate_count != 16'hFFFF)) begin
                gate_count <= gate_count + 16'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        deb_n   = deb;
        hold_n  = hold;
        fire    = 1'b0;
        if (blocked || !is_idle) begin
            state_n = S_WAIT_LOW;
            deb_n   = '0;
            hold_n  = '0;
        end else begin
            case (state)
                S_WAIT_LOW: begin
                    if (i_sampleValid && at_or_below_low) begin
                        state_n = S_ARMED;
                        deb_n   = '0;
                    end
                end
                S_ARMED: begin
                    // Invalid cycles leave deb untouched so gaps do not break debounce.
                    if (i_sampleValid) begin
                        if (above_high) begin
                            if (deb_inc == DEB_MAX) begin
                                fire    = 1'b1;
                                state_n = S_HOLDOFF;
                                deb_n   = '0;
                                hold_n  = '0;
                            end else begin
                                deb_n = deb_inc;
                            end
                        end else begin
                            deb_n = '0;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (hold == HOLD_LAST) begin
                        state_n = S_WAIT_LOW;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold + HOLD_W'(1);
                    end
                end
                default: begin
                    state_n = S_WAIT_LOW;
                    deb_n   = '0;
                    hold_n  = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        o_busy      = (state == S_ARMED) || (state == S_HOLDOFF);
        o_gate      = gate_q;
        o_cfgError  = cfg_error_q;
        o_gateCount = gate_count;
    end

endmodule

// File: doc/gate_detector.md
# gate_detector

Upstream stage of the IAGC watchdog: produces the `gate` pulse the watchdog consumes. Watches the IAGC input sample stream and emits a registered single-cycle gate pulse when the signal rises above a high threshold for a debounced number of consecutive samples, after having first been seen at or below a low threshold. Active only while the IAGC status is IDLE. Keeps a saturating count of emitted gates.

## Interface
- `DATA_SIZE`, 12, sample and threshold width (unsigned)
- `IAGC_STATUS_SIZE`, 4, width of IAGC status bus
- `IAGC_STATUS_INIT`, 4'b0001, status code that clears the gate counter
- `IAGC_STATUS_IDLE`, 4'b0010, only status in which detection runs
- `DEBOUNCE`, 4, consecutive valid samples ≥ high threshold required to fire (≥1)
- `HOLDOFF`, 16, clock cycles of dead time after a gate (≥1)
- `i_clock`  in  1  system clock; all logic on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_iagcStatus`  in  IAGC_STATUS_SIZE  current IAGC status
- `i_sampleValid`  in  1  qualifies `i_sample` this cycle
- `i_sample`  in  DATA_SIZE  unsigned input sample
- `i_thresholdHigh`  in  DATA_SIZE  fire level
- `i_thresholdLow`  in  DATA_SIZE  re-arm level
- `o_gate`  out  1  single-cycle gate pulse to watchdog `i_gate`
- `o_busy`  out  1  high in ARMED or HOLDOFF
- `o_cfgError`  out  1  registered, high while `i_thresholdLow ≥ i_thresholdHigh`
- `o_gateCount`  out  16  saturating count of emitted gates

## Operation
- States: WAIT_LOW, ARMED, HOLDOFF. Debounce counter `deb` (0..DEBOUNCE), holdoff counter `hold` (0..HOLDOFF-1).
- WAIT_LOW: on valid sample ≤ low → ARMED, `deb`=0. Otherwise stay.
- ARMED, valid sample:
  - ≥ high → `deb`+1; if new value == DEBOUNCE → `o_gate`=1 next cycle, enter HOLDOFF with `hold`=0, `deb`=0, `o_gateCount`+1 (saturates at 16'hFFFF).
  - < high → `deb`=0, stay ARMED (a sample ≤ low does not disarm).
- ARMED, `i_sampleValid`=0: no change to `deb`; gaps in valid do not break debounce.
- HOLDOFF: samples ignored; `hold` increments each cycle; at `hold`==HOLDOFF-1 → WAIT_LOW next cycle. Total HOLDOFF cycles spent in HOLDOFF.
- Status gating: whenever `i_iagcStatus` ≠ IDLE, next state is WAIT_LOW, `deb`=`hold`=0, `o_gate`=0; a gate that would fire that same cycle is suppressed and not counted. Status == INIT additionally clears `o_gateCount`.
- Config error: while `o_cfgError`=1, FSM forced to WAIT_LOW, counters cleared, no gates fire. `o_cfgError` is registered from the comparison (one cycle lag); the same-cycle comparison also blocks transitions.
- Thresholds may change at any time; comparisons use current-cycle values.
- Priority per cycle: reset > cfgError > status ≠ IDLE > FSM.

## Timing
- Reset: state WAIT_LOW, `deb`=0, `hold`=0, `o_gate`=0, `o_busy`=0, `o_cfgError`=0, `o_gateCount`=0.
- `o_gate` latency: high exactly one cycle, in the cycle after the edge that samples the DEBOUNCE-th qualifying sample. Never high two consecutive cycles.
- `o_busy` registered, reflects state (ARMED or HOLDOFF) with no additional lag beyond the state register.
- `o_gateCount` updates on the same edge that asserts `o_gate`.
- Minimum gate-to-gate spacing: HOLDOFF + 1 (re-arm sample) + DEBOUNCE cycles.
- Reset mid-HOLDOFF or mid-debounce: all state cleared next edge, no gate emitted.

## Test plan
- Reset then status IDLE, thresholds high=2000/low=500; samples 100, then 2500×4 valid every cycle → `o_gate` single pulse one cycle after the 4th 2500; `o_gateCount`=1; `o_busy` high 16 cycles of HOLDOFF then low.
- Same setup, samples 2500,2500,2500,1000,2500×4 → debounce restarts at 1000; one gate only after final 4th 2500.
- Samples 2500 without prior ≤500 → no gate (WAIT_LOW); feed 400 then 2500×4 → gate; feed 2500×40 more with no low sample → no second gate.
- Debounce at 3 of 4 then status → INIT → state WAIT_LOW, `o_gateCount`=0; return to IDLE needs fresh ≤500 before gating.
- Set low=2000/high=2000 → `o_cfgError`=1 next cycle, no gate for any stimulus; restore low=500 → `o_cfgError` clears, normal operation resumes.
- Preload count to 16'hFFFF via repeated gates (or forced) → further gate pulses still emitted, count stays 16'hFFFF; reset mid-HOLDOFF → all outputs at reset values next cycle.
